// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between N packet requesters.
// The grant is held for a whole packet; a watchdog reclaims it from an owner that stops presenting bytes.
module uart_tx_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned IDX_WIDTH = 2,
  parameter int unsigned TIMEOUT   = 65535,
  parameter int unsigned TO_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8*N-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic [7:0]       tx_data,
  output logic             tx_req,
  input  logic             tx_ready,
  output logic [N-1:0]     grant,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [TO_WIDTH-1:0] StallLast = TO_WIDTH'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] StallMax  = '1;
  localparam logic [IDX_WIDTH-1:0] LastIdx  = IDX_WIDTH'(N - 1);

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   owner_q, owner_d;
  logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TO_WIDTH-1:0]    stall_ctr_q, stall_ctr_d;

  logic [IDX_WIDTH-1:0]   pick_idx;
  logic                   pick_found;
  logic [IDX_WIDTH-1:0]   cand;
  logic [IDX_WIDTH-1:0]   owner_next;

  // First valid requester scanning upward from rr_ptr, wrapping modulo N.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_WIDTH'((32'(rr_ptr_q) + k) % N);
      if (!pick_found && in_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_next = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    stall_ctr_d = stall_ctr_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d     = StSend;
          owner_d     = pick_idx;
          stall_ctr_d = '0;
        end
      end
      StSend: begin
        if (in_valid[owner_q]) begin
          // A slow transmitter never counts as a stall.
          if (tx_ready) begin
            stall_ctr_d = '0;
            if (in_last[owner_q]) begin
              state_d  = StIdle;
              rr_ptr_d = owner_next;
            end
          end
        end else begin
          if (stall_ctr_q != StallMax) stall_ctr_d = stall_ctr_q + 1'b1;
          if (TIMEOUT != 0 && stall_ctr_q == StallLast) begin
            state_d  = StIdle;
            rr_ptr_d = owner_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = '0;
    grant    = '0;
    tx_data  = '0;
    tx_req   = 1'b0;
    busy     = 1'b0;
    if (state_q == StSend) begin
      busy              = 1'b1;
      grant[owner_q]    = 1'b1;
      tx_req            = in_valid[owner_q];
      tx_data           = in_data[32'(owner_q) * 8 +: 8];
      in_ready[owner_q] = tx_ready && in_valid[owner_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      stall_ctr_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_ctr_q <= stall_ctr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester byte queues, a frame-timed transmitter model and a
// packet-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int TO    = 8;
  localparam int FRAME = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  in_data;
  logic [3:0]   in_valid, in_last, in_ready, grant;
  logic [7:0]   tx_data;
  logic         tx_req, tx_ready, busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N(4), .IDX_WIDTH(2), .TIMEOUT(TO), .TO_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tx_data(tx_data), .tx_req(tx_req), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  logic [8:0] q[4][$];          // {last, byte} per requester
  int         acc_id[$];
  logic [7:0] acc_byte[$];
  logic [3:0] grant_log[$];
  int         model_ptr;
  bit         frame_mode;
  int         tx_cnt;

  function automatic int pick(int ptr, logic [3:0] pend);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] pending();
    logic [3:0] p;
    for (int i = 0; i < N; i++) p[i] = (q[i].size() != 0);
    return p;
  endfunction

  task automatic clear_logs();
    acc_id.delete();
    acc_byte.delete();
    grant_log.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        in_valid[i]       = 1'b1;
        in_last[i]        = q[i][0][8];
        in_data[8*i +: 8] = q[i][0][7:0];
      end else begin
        in_valid[i]       = 1'b0;
        in_last[i]        = 1'b0;
        in_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  // Sample on the falling edge, then apply the handshake effects after the rising edge.
  task automatic tick();
    logic [3:0] rdy;
    @(negedge clk);
    rdy = in_ready;
    grant_log.push_back(grant);
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) begin
        acc_id.push_back(i);
        acc_byte.push_back(tx_data);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rdy[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (frame_mode) begin
      if (|rdy) tx_cnt = FRAME;
      else if (tx_cnt > 0) tx_cnt--;
      tx_ready = (tx_cnt == 0);
    end
    drive();
  endtask

  task automatic run_until_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (grant_log[$] == 4'b0000 && pending() == 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    clear_logs();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'($urandom)});
    drive();
    reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_hold_grant: got %b want 0000", grant); end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [7:0] want_b[3];
    int own, bad, first, lastnz;
    bit ok;
    want_b = '{8'h41, 8'h42, 8'h43};
    clear_logs();
    frame_mode = 1'b1;
    tx_cnt = 0;
    tx_ready = 1'b1;
    for (int j = 0; j < 3; j++) q[2].push_back({(j == 2), want_b[j]});
    own = pick(model_ptr, pending());
    drive();
    run_until_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got 0 want 1"); end
    checks++; if (acc_byte.size() != 3) begin errors++; $display("FAIL single_count: got %0d want 3", acc_byte.size()); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (j >= acc_byte.size() || acc_byte[j] !== want_b[j] || acc_id[j] != own) begin
        errors++;
        $display("FAIL single_byte%0d: got %h want %h", j, (j < acc_byte.size()) ? acc_byte[j] : 8'hxx, want_b[j]);
      end
    end
    bad = 0; first = -1; lastnz = -1;
    foreach (grant_log[t]) begin
      if (grant_log[t] != 0) begin
        if (grant_log[t] != 4'(1 << own)) bad++;
        if (first < 0) first = t;
        lastnz = t;
      end
    end
    for (int t = first; t >= 0 && t <= lastnz; t++) if (grant_log[t] == 0) bad++;
    checks++; if (bad != 0 || first < 0) begin errors++; $display("FAIL single_grant: got %0d bad cycles want 0", bad); end
    model_ptr = (own + 1) % N;
    frame_mode = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] b[2];
    int want_id[2];
    int ptr;
    logic [3:0] pend;
    bit ok;
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      b[i] = 8'($urandom);
      q[i].push_back({1'b1, b[i]});
    end
    ptr = model_ptr;
    pend = pending();
    for (int j = 0; j < 2; j++) begin
      want_id[j] = pick(ptr, pend);
      pend[want_id[j]] = 1'b0;
      ptr = (want_id[j] + 1) % N;
    end
    drive();
    run_until_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done: got 0 want 1"); end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (j >= acc_id.size() || acc_id[j] != want_id[j] || acc_byte[j] !== b[want_id[j]]) begin
        errors++;
        $display("FAIL wrap_order%0d: got %0d want %0d", j, (j < acc_id.size()) ? acc_id[j] : -1, want_id[j]);
      end
    end
    model_ptr = ptr;
  endtask

  task automatic test_round_robin();
    logic [8:0] mq[4][$];
    int want_id[$];
    logic [7:0] want_b[$];
    int want_own[$];
    logic [3:0] runs[$];
    int gaps[$];
    int ptr, zeros;
    logic [3:0] prev, p;
    bit ok;
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++) begin
        q[i].push_back({1'b0, 8'($urandom)});
        q[i].push_back({1'b1, 8'($urandom)});
      end
    for (int i = 0; i < N; i++) mq[i] = q[i];
    ptr = model_ptr;
    forever begin
      int o;
      logic [8:0] e;
      for (int i = 0; i < N; i++) p[i] = (mq[i].size() != 0);
      if (p == 0) break;
      o = pick(ptr, p);
      want_own.push_back(o);
      do begin
        e = mq[o].pop_front();
        want_id.push_back(o);
        want_b.push_back(e[7:0]);
      end while (!e[8]);
      ptr = (o + 1) % N;
    end
    drive();
    run_until_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_done: got 0 want 1"); end
    checks++; if (acc_byte.size() != want_b.size()) begin errors++; $display("FAIL rr_count: got %0d want %0d", acc_byte.size(), want_b.size()); end
    foreach (want_b[j]) begin
      checks++;
      if (j >= acc_byte.size() || acc_id[j] != want_id[j] || acc_byte[j] !== want_b[j]) begin
        errors++;
        $display("FAIL rr_byte%0d: got id %0d want id %0d data %h", j, (j < acc_id.size()) ? acc_id[j] : -1, want_id[j], want_b[j]);
      end
    end
    prev = 0; zeros = 0;
    foreach (grant_log[t]) begin
      if (grant_log[t] != 0) begin
        if (prev == 0 || grant_log[t] != prev) begin
          runs.push_back(grant_log[t]);
          if (runs.size() > 1) gaps.push_back(zeros);
        end
        zeros = 0;
      end else zeros++;
      prev = grant_log[t];
    end
    checks++; if (runs.size() != want_own.size()) begin errors++; $display("FAIL rr_packets: got %0d want %0d", runs.size(), want_own.size()); end
    foreach (want_own[j]) begin
      checks++;
      if (j >= runs.size() || runs[j] != 4'(1 << want_own[j])) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", j, (j < runs.size()) ? runs[j] : 4'bxxxx, 4'(1 << want_own[j]));
      end
    end
    foreach (gaps[j]) begin
      checks++;
      if (gaps[j] != 1) begin errors++; $display("FAIL rr_gap%0d: got %0d want 1", j, gaps[j]); end
    end
    model_ptr = ptr;
  endtask

  task automatic test_stall_timeout();
    logic [7:0] a, b3a, b3b, s0, s1;
    int held, want;
    bit ok;
    clear_logs();
    a = 8'($urandom);
    q[1].push_back({1'b0, a});
    want = pick(model_ptr, pending());
    drive();
    for (int c = 0; c < 50; c++) begin
      tick();
      if (acc_byte.size() > 0) break;
    end
    checks++;
    if (acc_byte.size() != 1 || acc_byte[0] !== a || acc_id[0] != want) begin
      errors++; $display("FAIL stall_first_byte: got %0d bytes want 1 byte %h", acc_byte.size(), a);
    end
    b3a = 8'($urandom); b3b = 8'($urandom);
    q[3].push_back({1'b0, b3a});
    q[3].push_back({1'b1, b3b});
    drive();
    held = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (grant_log[$] == 4'(1 << want)) held++;
      else break;
    end
    checks++; if (held != TO) begin errors++; $display("FAIL stall_held: got %0d cycles want %0d", held, TO); end
    checks++; if (grant_log[$] != 4'b0) begin errors++; $display("FAIL stall_idle: got %b want 0000", grant_log[$]); end
    model_ptr = (want + 1) % N;
    want = pick(model_ptr, pending());
    tick();
    checks++; if (grant_log[$] != 4'(1 << want)) begin errors++; $display("FAIL stall_next_grant: got %b want %b", grant_log[$], 4'(1 << want)); end
    run_until_idle(100, ok);
    checks++;
    if (!ok || acc_byte.size() != 3 || acc_byte[1] !== b3a || acc_byte[2] !== b3b || acc_id[2] != want) begin
      errors++; $display("FAIL stall_pending_pkt: got %0d bytes want 3", acc_byte.size());
    end
    model_ptr = (want + 1) % N;

    clear_logs();
    tx_ready = 1'b0;
    s0 = 8'($urandom); s1 = 8'($urandom);
    q[1].push_back({1'b0, s0});
    q[1].push_back({1'b1, s1});
    want = pick(model_ptr, pending());
    drive();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (grant_log[$] != 0) break;
    end
    checks++; if (grant_log[$] != 4'(1 << want)) begin errors++; $display("FAIL slow_grant: got %b want %b", grant_log[$], 4'(1 << want)); end
    held = 0;
    repeat (100) begin
      tick();
      if (grant_log[$] == 4'(1 << want)) held++;
    end
    checks++; if (held != 100) begin errors++; $display("FAIL slow_held: got %0d cycles want 100", held); end
    checks++; if (acc_byte.size() != 0) begin errors++; $display("FAIL slow_no_accept: got %0d want 0", acc_byte.size()); end
    tx_ready = 1'b1;
    run_until_idle(50, ok);
    checks++;
    if (!ok || acc_byte.size() != 2 || acc_byte[0] !== s0 || acc_byte[1] !== s1) begin
      errors++; $display("FAIL slow_bytes: got %0d bytes want 2", acc_byte.size());
    end
    model_ptr = (want + 1) % N;
  endtask

  task automatic test_reset_mid_packet();
    int want0, want1;
    bit ok;
    clear_logs();
    for (int j = 0; j < 4; j++) q[0].push_back({(j == 3), 8'($urandom)});
    drive();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (acc_byte.size() >= 1) break;
    end
    checks++; if (acc_byte.size() != 1 || acc_id[0] != 0) begin errors++; $display("FAIL mid_first_byte: got %0d bytes want 1", acc_byte.size()); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL mid_grant: got %b want 0000", grant); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL mid_tx_req: got %b want 0", tx_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    clear_logs();
    q[1].push_back({1'b1, 8'($urandom)});
    q[3].push_back({1'b1, 8'($urandom)});
    want0 = pick(model_ptr, pending());
    want1 = pick((want0 + 1) % N, pending() & ~4'(1 << want0));
    drive();
    tick();
    checks++; if (grant_log[$] != 4'(1 << want0)) begin errors++; $display("FAIL mid_regrant: got %b want %b", grant_log[$], 4'(1 << want0)); end
    run_until_idle(50, ok);
    checks++;
    if (!ok || acc_id.size() != 2 || acc_id[0] != want0 || acc_id[1] != want1) begin
      errors++; $display("FAIL mid_order: got %0d accepts want ids %0d,%0d", acc_id.size(), want0, want1);
    end
    model_ptr = (want1 + 1) % N;
  endtask

  task automatic test_simultaneous();
    logic [7:0] z;
    int want;
    bit ok;
    clear_logs();
    q[1].push_back({1'b0, 8'($urandom)});
    q[1].push_back({1'b1, 8'($urandom)});
    drive();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (acc_byte.size() >= 1) break;
    end
    z = 8'($urandom);
    q[2].push_back({1'b1, z});
    drive();
    tick();
    checks++;
    if (grant_log[$] != 4'b0010 || acc_id.size() != 2 || acc_id[1] != 1) begin
      errors++; $display("FAIL simul_last_accept: got grant %b accepts %0d want 0010 and 2", grant_log[$], acc_id.size());
    end
    model_ptr = 2;
    want = pick(model_ptr, pending());
    tick();
    checks++; if (grant_log[$] != 4'b0) begin errors++; $display("FAIL simul_idle: got %b want 0000", grant_log[$]); end
    tick();
    checks++; if (grant_log[$] != 4'(1 << want)) begin errors++; $display("FAIL simul_grant: got %b want %b", grant_log[$], 4'(1 << want)); end
    run_until_idle(30, ok);
    checks++;
    if (!ok || acc_byte.size() != 3 || acc_byte[2] !== z) begin
      errors++; $display("FAIL simul_byte: got %0d bytes want 3 ending %h", acc_byte.size(), z);
    end
  endtask

  initial begin
    in_data = '0;
    in_valid = '0;
    in_last = '0;
    tx_ready = 1'b1;
    frame_mode = 1'b0;
    tx_cnt = 0;
    model_ptr = 0;
    test_reset();
    test_single_packet();
    test_pointer_wrap();
    test_round_robin();
    test_stall_timeout();
    test_reset_mid_packet();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter (valid/ready byte interface, `req`/`ready`/`data`) between N requesters.
- Each requester sends multi-byte packets; the grant is held for a whole packet, so bytes from different requesters never interleave on the line.
- Arbitration between packets is round-robin.
- A watchdog reclaims the grant from a requester that stalls mid-packet.

Parameters:
- N, 4, number of requesters (2..16).
- IDX_WIDTH, 2, width of requester index; must satisfy 2**IDX_WIDTH >= N.
- TIMEOUT, 65535, number of consecutive stalled cycles (owner in_valid low) before the grant is revoked. 0 disables the watchdog.
- TO_WIDTH, 16, width of the stall counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_data  in  8*N  byte from requester i on bits [8i+7:8i].
- in_valid  in  N  requester i presents a byte.
- in_last  in  N  requester i's current byte is the last of its packet.
- in_ready  out  N  byte i accepted this cycle (one-hot or zero).
- tx_data  out  8  byte to the transmitter.
- tx_req  out  1  byte valid toward the transmitter.
- tx_ready  in  1  transmitter idle; a byte transfers on a cycle with tx_req && tx_ready.
- grant  out  N  one-hot current owner; zero in IDLE.
- busy  out  1  high in SEND.

Behaviour:
- Reset values: state=IDLE, owner=0, rr_ptr=0, stall_ctr=0.
  - Outputs at reset: grant=0, busy=0, tx_req=0, in_ready=0, tx_data=0.
- FSM with two states, IDLE and SEND.
- IDLE:
  - If any in_valid is high, the next owner is the first i with in_valid[i] set, scanning from rr_ptr upward and wrapping modulo N.
  - Next state is SEND with owner registered and stall_ctr=0.
  - If no in_valid is high, stay in IDLE.
  - Arbitration latency: one cycle from in_valid rising to grant.
- SEND outputs (combinational from registered owner):
  - tx_data = in_data[owner].
  - tx_req = in_valid[owner].
  - in_ready[owner] = tx_ready && in_valid[owner]; all other in_ready bits are 0.
- SEND, byte accepted (tx_req && tx_ready):
  - stall_ctr is cleared.
  - If in_last[owner] is set: next state is IDLE and rr_ptr = owner+1 (wraps at N to 0).
- SEND, owner in_valid low: stall_ctr increments (saturating).
  - If TIMEOUT != 0 and stall_ctr == TIMEOUT-1, go to IDLE with rr_ptr = owner+1.
  - The requester's remaining bytes are simply re-arbitrated later; there is no error flag.
- SEND, owner valid but tx_ready low: stall_ctr is not incremented. A slow transmitter is never a stall.
- Packet boundaries:
  - After a packet ends, one IDLE cycle always follows, even when other requesters are waiting. This is deterministic and also gives the transmitter's ready time to fall.
  - Requests from non-owners during SEND are ignored and must be held until granted.
  - A single-byte packet (in_last with the first byte) is legal.
  - in_last is sampled only when the byte is accepted.
- tx_data outside SEND: 0.
- Fairness: with all N requesters continuously valid, grants cycle 0,1,…,N-1,0.
- Mid-operation reset:
  - FSM returns to IDLE asynchronously and tx_req drops.
  - A byte already handed to the transmitter finishes on the line, because the transmitter is not reset by this block.
- Requester contract: in_valid, once high, must stay high with in_data/in_last stable until in_ready. This is not checked.

Test Plan:
1. Single packet: requester 2 sends 0x41,0x42,0x43 (last on 0x43) with tx_ready toggling as a 10-bit frame transmitter would.
   - Expect tx_data sequence 0x41,0x42,0x43, each accepted exactly once.
   - grant=4'b0100 throughout the packet, then IDLE and rr_ptr=3.
2. Round-robin: all 4 requesters continuously valid with 2-byte packets.
   - Expect grant order 0,1,2,3,0 and exactly one IDLE cycle between packets.
   - No byte of one packet appears between bytes of another.
3. Pointer wrap: rr_ptr=3, requesters 0 and 1 valid.
   - Expect requester 0 granted, then requester 1.
4. Stall timeout: TIMEOUT=8; requester 1 sends one byte then drops valid.
   - Expect grant revoked after 8 stalled cycles.
   - A pending requester 3 is then granted.
   - A 100-cycle tx_ready-low period with valid held must not trigger the timeout.
5. Reset mid-packet: assert reset during byte 2 of a 4-byte packet from requester 0.
   - Expect grant=0, tx_req=0 and busy=0 immediately, without waiting for a clk edge.
   - After release, rr_ptr=0 and a new request is granted after one cycle.
6. Simultaneous events: requester 1 issues a last-byte accept while requester 2 raises valid in the same cycle.
   - Expect IDLE next cycle, then grant=4'b0100.
